// File: rtl/cpu_port_exerciser.sv
// Write/read-back soak initiator for the sdram_ctrl CPU port: sweeps a word range
// with a seeded pattern and reports errors. Define EXERCISER_BYTE_EN for byte-lane passes.
module cpu_port_exerciser #(
    parameter logic [15:0] SEED    = 16'hA5A5,
    parameter int          GAP     = 2,
    parameter int          TIMEOUT = 1023
) (
    input  logic        sysclk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [24:0] base,
    input  logic [15:0] count,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [24:0] first_fail_addr,
    output logic [24:0] cpuAddr,
    output logic [3:0]  cpustate,
    output logic        cpuL,
    output logic        cpuU,
    output logic [15:0] cpuWR,
    input  logic [15:0] cpuRD,
    input  logic        enaWRreg,
    input  logic        cpuena
);

    localparam logic [15:0] GAP_LAST = 16'(GAP - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_WR_REQ = 4'd1,
        ST_WR_GAP = 4'd2,
        ST_RD_REQ = 4'd3,
        ST_RD_GAP = 4'd4,
`ifdef EXERCISER_BYTE_EN
        ST_BW_REQ = 4'd5,
        ST_BW_GAP = 4'd6,
        ST_BR_REQ = 4'd7,
        ST_BR_GAP = 4'd8,
`endif
        ST_FIN    = 4'd9
    } state_t;

    function automatic logic [15:0] pattern(input logic [24:0] a);
        return a[15:0] ^ SEED;
    endfunction

    // BR reads back a word whose upper byte was overwritten with the inverted pattern
    function automatic logic [15:0] expect_word(input state_t s, input logic [24:0] a);
        logic [15:0] p;
        p = pattern(a);
        case (s)
`ifdef EXERCISER_BYTE_EN
            ST_BR_REQ: return {~p[15:8], p[7:0]};
`endif
            default:   return p;
        endcase
    endfunction

    function automatic logic is_read(input state_t s);
        case (s)
            ST_RD_REQ: return 1'b1;
`ifdef EXERCISER_BYTE_EN
            ST_BR_REQ: return 1'b1;
`endif
            default:   return 1'b0;
        endcase
    endfunction

    function automatic state_t gap_of(input state_t s);
        case (s)
            ST_WR_REQ: return ST_WR_GAP;
            ST_RD_REQ: return ST_RD_GAP;
`ifdef EXERCISER_BYTE_EN
            ST_BW_REQ: return ST_BW_GAP;
            ST_BR_REQ: return ST_BR_GAP;
`endif
            default:   return ST_FIN;
        endcase
    endfunction

    function automatic state_t req_of(input state_t s);
        case (s)
            ST_WR_GAP: return ST_WR_REQ;
            ST_RD_GAP: return ST_RD_REQ;
`ifdef EXERCISER_BYTE_EN
            ST_BW_GAP: return ST_BW_REQ;
            ST_BR_GAP: return ST_BR_REQ;
`endif
            default:   return ST_FIN;
        endcase
    endfunction

    function automatic state_t next_pass(input state_t s);
        case (s)
            ST_WR_GAP: return ST_RD_REQ;
`ifdef EXERCISER_BYTE_EN
            ST_RD_GAP: return ST_BW_REQ;
            ST_BW_GAP: return ST_BR_REQ;
`endif
            default:   return ST_FIN;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [24:0] base_q, base_d;
    logic [15:0] count_q, count_d;
    logic [15:0] idx_q, idx_d;
    logic [24:0] addr_q, addr_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] tmo_q, tmo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic [15:0] err_count_q, err_count_d;
    logic [24:0] ffa_q, ffa_d;
    logic [24:0] cpu_addr_q, cpu_addr_d;
    logic [3:0]  cpu_state_q, cpu_state_d;
    logic        cpu_l_q, cpu_l_d;
    logic        cpu_u_q, cpu_u_d;
    logic [15:0] cpu_wr_q, cpu_wr_d;
    logic        accept_s;

    assign accept_s = enaWRreg && cpuena;

    // Sequencer: pass/word progression, acceptance, timeout and status bookkeeping
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        gap_d       = gap_q;
        tmo_d       = tmo_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        err_count_d = err_count_q;
        ffa_d       = ffa_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    timeout_d   = 1'b0;
                    err_count_d = 16'd0;
                    ffa_d       = 25'd0;
                    base_d      = base;
                    count_d     = count;
                    idx_d       = 16'd0;
                    addr_d      = base;
                    tmo_d       = 16'd0;
                    if (count != 16'd0) begin
                        busy_d  = 1'b1;
                        state_d = ST_WR_REQ;
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef EXERCISER_BYTE_EN
            ST_WR_REQ, ST_RD_REQ, ST_BW_REQ, ST_BR_REQ: begin
`else
            ST_WR_REQ, ST_RD_REQ: begin
`endif
                if (accept_s) begin
                    state_d = gap_of(state_q);
                    gap_d   = 16'd0;
                    if (is_read(state_q) && (cpuRD != expect_word(state_q, addr_q))) begin
                        // a saturating counter never returns to zero, so zero means "no miss yet"
                        if (err_count_q == 16'd0) begin
                            ffa_d = addr_q;
                        end else begin
                            ffa_d = ffa_q;
                        end
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end else begin
                            err_count_d = err_count_q;
                        end
                    end else begin
                        err_count_d = err_count_q;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
`ifdef EXERCISER_BYTE_EN
            ST_WR_GAP, ST_RD_GAP, ST_BW_GAP, ST_BR_GAP: begin
`else
            ST_WR_GAP, ST_RD_GAP: begin
`endif
                if (gap_q == GAP_LAST) begin
                    tmo_d = 16'd0;
                    if ((idx_q + 16'd1) == count_q) begin
                        idx_d   = 16'd0;
                        addr_d  = base_q;
                        state_d = next_pass(state_q);
                    end else begin
                        idx_d   = idx_q + 16'd1;
                        addr_d  = addr_q + 25'd1;
                        state_d = req_of(state_q);
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                pass_d  = (err_count_q == 16'd0) && !timeout_q;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Bus drive derived from the next state so requests are registered and glitch-free
    always_comb begin
        cpu_addr_d  = cpu_addr_q;
        cpu_state_d = 4'b0101;
        cpu_l_d     = 1'b1;
        cpu_u_d     = 1'b1;
        cpu_wr_d    = cpu_wr_q;
        case (state_d)
            ST_WR_REQ: begin
                cpu_addr_d  = addr_d;
                cpu_state_d = 4'b0011;
                cpu_l_d     = 1'b0;
                cpu_u_d     = 1'b0;
                cpu_wr_d    = pattern(addr_d);
            end
            ST_RD_REQ: begin
                cpu_addr_d  = addr_d;
                cpu_state_d = 4'b0010;
                cpu_l_d     = 1'b0;
                cpu_u_d     = 1'b0;
            end
`ifdef EXERCISER_BYTE_EN
            ST_BW_REQ: begin
                cpu_addr_d  = addr_d;
                cpu_state_d = 4'b0011;
                cpu_l_d     = 1'b1;
                cpu_u_d     = 1'b0;
                cpu_wr_d    = ~pattern(addr_d);
            end
            ST_BR_REQ: begin
                cpu_addr_d  = addr_d;
                cpu_state_d = 4'b0010;
                cpu_l_d     = 1'b0;
                cpu_u_d     = 1'b0;
            end
`endif
            default: begin
                cpu_state_d = 4'b0101;
                cpu_l_d     = 1'b1;
                cpu_u_d     = 1'b1;
            end
        endcase
    end

    // State, status and bus registers
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            base_q      <= 25'd0;
            count_q     <= 16'd0;
            idx_q       <= 16'd0;
            addr_q      <= 25'd0;
            gap_q       <= 16'd0;
            tmo_q       <= 16'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_count_q <= 16'd0;
            ffa_q       <= 25'd0;
            cpu_addr_q  <= 25'd0;
            cpu_state_q <= 4'b0101;
            cpu_l_q     <= 1'b1;
            cpu_u_q     <= 1'b1;
            cpu_wr_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            err_count_q <= err_count_d;
            ffa_q       <= ffa_d;
            cpu_addr_q  <= cpu_addr_d;
            cpu_state_q <= cpu_state_d;
            cpu_l_q     <= cpu_l_d;
            cpu_u_q     <= cpu_u_d;
            cpu_wr_q    <= cpu_wr_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign timeout         = timeout_q;
    assign err_count       = err_count_q;
    assign first_fail_addr = ffa_q;
    assign cpuAddr         = cpu_addr_q;
    assign cpustate        = cpu_state_q;
    assign cpuL            = cpu_l_q;
    assign cpuU            = cpu_u_q;
    assign cpuWR           = cpu_wr_q;

endmodule

// File: tb/tb_cpu_port_exerciser.sv
// Directed bench for cpu_port_exerciser with a behavioural sdram_ctrl CPU-port stub.
module tb_cpu_port_exerciser;

`ifdef EXERCISER_BYTE_EN
    localparam int PM = 2;
`else
    localparam int PM = 1;
`endif

    logic        sysclk;
    logic        reset_n;
    logic        start;
    logic [24:0] base;
    logic [15:0] count;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [24:0] first_fail_addr;
    logic [24:0] cpuAddr;
    logic [3:0]  cpustate;
    logic        cpuL, cpuU;
    logic [15:0] cpuWR;
    logic [15:0] cpuRD;
    logic        enaWRreg;
    logic        cpuena;

    cpu_port_exerciser #(.SEED(16'hA5A5), .GAP(2), .TIMEOUT(1023)) dut (
        .sysclk(sysclk), .reset_n(reset_n), .start(start), .base(base), .count(count),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
        .first_fail_addr(first_fail_addr), .cpuAddr(cpuAddr), .cpustate(cpustate),
        .cpuL(cpuL), .cpuU(cpuU), .cpuWR(cpuWR), .cpuRD(cpuRD),
        .enaWRreg(enaWRreg), .cpuena(cpuena)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // memory stub state and transaction logs
    logic        stub_never;
    logic        flip_en;
    logic [24:0] flip_addr;
    int          age;
    int          wr_n, rd_n;
    logic [24:0] wr_a [16];
    logic [15:0] wr_d [16];
    logic [1:0]  wr_ul [16];
    logic [24:0] rd_a [16];
    logic [15:0] rd_d [16];
    logic [15:0] mem [logic [24:0]];
    logic [15:0] cur;

    initial begin
        cpuena   = 1'b0;
        enaWRreg = 1'b1;
        cpuRD    = 16'h0000;
        age      = 0;
        forever begin
            @(negedge sysclk);
            if (reset_n && (cpustate == 4'b0011 || cpustate == 4'b0010)) begin
                age = age + 1;
                cpuena = (!stub_never && age == 4);
                if (cpuena) begin
                    cur = mem.exists(cpuAddr) ? mem[cpuAddr] : 16'h0000;
                    if (cpustate == 4'b0011) begin
                        if (!cpuU) cur[15:8] = cpuWR[15:8];
                        if (!cpuL) cur[7:0] = cpuWR[7:0];
                        mem[cpuAddr] = cur;
                        if (wr_n < 16) begin
                            wr_a[wr_n] = cpuAddr;
                            wr_d[wr_n] = cpuWR;
                            wr_ul[wr_n] = {cpuU, cpuL};
                        end
                        wr_n = wr_n + 1;
                    end else begin
                        if (flip_en && cpuAddr == flip_addr) begin
                            cur = cur ^ 16'h0001;
                            flip_en = 1'b0;
                        end
                        cpuRD = cur;
                        if (rd_n < 16) begin
                            rd_a[rd_n] = cpuAddr;
                            rd_d[rd_n] = cur;
                        end
                        rd_n = rd_n + 1;
                    end
                end
            end else begin
                age = 0;
                cpuena = 1'b0;
            end
        end
    end

    task automatic clear_logs;
        wr_n = 0;
        rd_n = 0;
    endtask

    task automatic pulse_start;
        @(negedge sysclk);
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int k;
        k = 0;
        while (!done && k < limit) begin
            @(negedge sysclk);
            k++;
        end
        check_val(tag, {31'd0, done}, 32'd1);
    endtask

    logic [15:0] exp_a [4];
    int          k;

    initial begin
        exp_a = '{16'hA4A5, 16'hA4A4, 16'hA4A7, 16'hA4A6};
        reset_n = 1'b0; start = 1'b0; base = 25'd0; count = 16'd0;
        stub_never = 1'b0; flip_en = 1'b0; flip_addr = 25'd0;
        clear_logs();
        repeat (3) @(negedge sysclk);
        check_val("rst_cpustate", cpustate, 4'b0101);
        check_val("rst_lu", {cpuL, cpuU}, 2'b11);
        check_val("rst_addr", cpuAddr, 25'd0);
        check_val("rst_wr", cpuWR, 16'd0);
        check_val("rst_flags", {busy, done, pass, timeout}, 4'b0000);
        check_val("rst_err", err_count, 16'd0);
        check_val("rst_ffa", first_fail_addr, 25'd0);
        reset_n = 1'b1;
        @(negedge sysclk);

        // clean run over 0x100..0x103
        clear_logs();
        base = 25'h100; count = 16'd4;
        pulse_start();
        check_val("a_busy", busy, 1'b1);
        wait_done(600, "a_done");
        check_val("a_wr_n", wr_n, 4 * PM);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("a_wr_addr%0d", i), wr_a[i], 25'h100 + 25'(i));
            check_val($sformatf("a_wr_data%0d", i), wr_d[i], exp_a[i]);
            check_val($sformatf("a_rd_addr%0d", i), rd_a[i], 25'h100 + 25'(i));
        end
        check_val("a_rd_n", rd_n, 4 * PM);
        check_val("a_status", {busy, pass, timeout}, 3'b010);
        check_val("a_err", err_count, 16'd0);

        // same run, read at 0x102 corrupted once
        clear_logs();
        flip_addr = 25'h102; flip_en = 1'b1;
        pulse_start();
        check_val("b_done_clr", {done, busy}, 2'b01);
        wait_done(600, "b_done");
        check_val("b_err", err_count, 16'd1);
        check_val("b_ffa", first_fail_addr, 25'h102);
        check_val("b_pass", pass, 1'b0);

        // wrap-around, plus a start pulse while busy
        clear_logs();
        base = 25'h1FFFFFF; count = 16'd2;
        pulse_start();
        repeat (5) @(negedge sysclk);
        base = 25'h55; count = 16'd7;
        pulse_start();
        check_val("w_busy", busy, 1'b1);
        wait_done(600, "w_done");
        check_val("w_wr_n", wr_n, 2 * PM);
        check_val("w_addr0", wr_a[0], 25'h1FFFFFF);
        check_val("w_addr1", wr_a[1], 25'h0000000);
        check_val("w_data0", wr_d[0], 16'h5A5A);
        check_val("w_data1", wr_d[1], 16'hA5A5);
        check_val("w_rd_n", rd_n, 2 * PM);
        check_val("w_pass", pass, 1'b1);

        // count of zero finishes without touching the bus
        clear_logs();
        base = 25'h10; count = 16'd0;
        @(negedge sysclk);
        start = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        check_val("z_first", {done, busy}, 2'b00);
        @(negedge sysclk);
        check_val("z_done_pass", {done, pass}, 2'b11);
        repeat (4) @(negedge sysclk);
        check_val("z_no_bus", wr_n + rd_n, 0);
        check_val("z_idle", cpustate, 4'b0101);

`ifdef EXERCISER_BYTE_EN
        clear_logs();
        base = 25'd0; count = 16'd1;
        pulse_start();
        wait_done(600, "be_done");
        check_val("be_wr_n", wr_n, 2);
        check_val("be_bw_data", wr_d[1], 16'h5A5A);
        check_val("be_bw_ul", wr_ul[1], 2'b01);
        check_val("be_rd_n", rd_n, 2);
        check_val("be_br_data", rd_d[1], 16'h5AA5);
        check_val("be_pass", pass, 1'b1);
`endif

        // acceptance never comes: abort after 1023 cycles in WR_REQ
        clear_logs();
        stub_never = 1'b1;
        base = 25'h20; count = 16'd1;
        pulse_start();
        check_val("t_req", cpustate, 4'b0011);
        k = 0;
        while (cpustate == 4'b0011 && k < 1100) begin
            @(negedge sysclk);
            k++;
        end
        check_val("t_cycles", k, 1023);
        check_val("t_bus_idle", {cpustate, cpuL, cpuU}, {4'b0101, 2'b11});
        wait_done(10, "t_done");
        check_val("t_flags", {timeout, pass, busy}, 3'b100);

        // async reset while a write request is held
        clear_logs();
        base = 25'h40; count = 16'd3;
        pulse_start();
        check_val("r_req", cpustate, 4'b0011);
        repeat (3) @(negedge sysclk);
        reset_n = 1'b0;
        #1;
        check_val("r_cpustate", cpustate, 4'b0101);
        check_val("r_lu", {cpuL, cpuU}, 2'b11);
        check_val("r_flags", {busy, done}, 2'b00);
        check_val("r_err", err_count, 16'd0);
        @(negedge sysclk);
        reset_n = 1'b1;
        stub_never = 1'b0;
        repeat (3) @(negedge sysclk);
        check_val("r_stay_idle", {cpustate, busy}, {4'b0101, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
